// File: rtl/mem_line_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_line_arbiter_if
//
// Bundles every handshake/bus signal around mem_line_arbiter:
//   C1_*  requester port 1 (instruction-cache miss engine)
//   C2_*  requester port 2 (data-cache miss/writeback engine)
//   M_*   word-serial request/acknowledge port to the backing memory
//
// Modports:
//   slave  - the arbiter itself (consumes requests, drives grants and M_*)
//   master - the environment: both cache controllers plus the memory model
// ---------------------------------------------------------------------------
interface mem_line_arbiter_if;

   // requester port 1
   logic        C1_REQ;
   logic        C1_WE;
   logic [31:0] C1_ADDR;
   logic [31:0] C1_WDATA;
   logic        C1_GNT;
   logic [31:0] C1_RDATA;
   logic        C1_RVALID;
   logic        C1_WNEXT;
   logic        C1_DONE;

   // requester port 2
   logic        C2_REQ;
   logic        C2_WE;
   logic [31:0] C2_ADDR;
   logic [31:0] C2_WDATA;
   logic        C2_GNT;
   logic [31:0] C2_RDATA;
   logic        C2_RVALID;
   logic        C2_WNEXT;
   logic        C2_DONE;

   // backing-memory port
   logic        M_EN;
   logic        M_WE;
   logic [31:0] M_ADDR;
   logic [31:0] M_WDATA;
   logic [31:0] M_RDATA;
   logic        M_ACK;

   modport slave (
      input  C1_REQ, C1_WE, C1_ADDR, C1_WDATA,
      input  C2_REQ, C2_WE, C2_ADDR, C2_WDATA,
      input  M_RDATA, M_ACK,
      output C1_GNT, C1_RDATA, C1_RVALID, C1_WNEXT, C1_DONE,
      output C2_GNT, C2_RDATA, C2_RVALID, C2_WNEXT, C2_DONE,
      output M_EN, M_WE, M_ADDR, M_WDATA
   );

   modport master (
      output C1_REQ, C1_WE, C1_ADDR, C1_WDATA,
      output C2_REQ, C2_WE, C2_ADDR, C2_WDATA,
      output M_RDATA, M_ACK,
      input  C1_GNT, C1_RDATA, C1_RVALID, C1_WNEXT, C1_DONE,
      input  C2_GNT, C2_RDATA, C2_RVALID, C2_WNEXT, C2_DONE,
      input  M_EN, M_WE, M_ADDR, M_WDATA
   );

endinterface

// File: rtl/mem_line_arbiter.sv
// ---------------------------------------------------------------------------
// mem_line_arbiter
//
// Shares the single backing-memory port between the instruction-cache miss
// engine (port 1) and the data-cache miss/writeback engine (port 2). Every
// grant covers one whole cache-line burst of WORDS word beats, either a fill
// (read) or a writeback (write). The memory side is word-serial: a beat is
// presented with M_EN and held until M_ACK, so any number of wait states is
// tolerated.
//
// Parameters:
//   WORDS   beats per line burst (power of two, >= 2; 8 = 32-byte line)
//
// Ports:
//   MEM_CLK  clock, all state changes on the rising edge
//   MEM_RST  asynchronous active-high reset
//   bus      mem_line_arbiter_if.slave
//              C1_*/C2_*  request (REQ/WE/ADDR/WDATA in; GNT/RDATA/RVALID/
//                         WNEXT/DONE out)
//              M_*        memory request (EN/WE/ADDR/WDATA out; RDATA/ACK in)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate owners
//                       undefined -> fixed priority, port 2 wins every tie
//
// Timing notes:
//   GNT, DONE, M_EN, M_WE and M_ADDR are decoded from registered state only.
//   RDATA, RVALID, WNEXT and M_WDATA are combinational pass-through paths
//   from M_ACK, M_RDATA and Cx_WDATA, gated by the BURST state so that every
//   output reads zero while reset is applied.
// ---------------------------------------------------------------------------
module mem_line_arbiter #(
   parameter int WORDS = 8
) (
   input  logic              MEM_CLK,
   input  logic              MEM_RST,
   mem_line_arbiter_if.slave bus
);

   localparam int BEAT_W   = $clog2(WORDS);
   // lowest address bit that belongs to the line number
   localparam int LINE_LSB = BEAT_W + 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // ------------------------------------------------------------------
   // Requester inputs gathered into per-port arrays (index 0 = port 1)
   // ------------------------------------------------------------------
   logic [1:0]  req;
   logic [1:0]  we_in;
   logic [31:0] addr_in  [2];
   logic [31:0] wdata_in [2];

   assign req         = {bus.C2_REQ, bus.C1_REQ};
   assign we_in       = {bus.C2_WE, bus.C1_WE};
   assign addr_in[0]  = bus.C1_ADDR;
   assign addr_in[1]  = bus.C2_ADDR;
   assign wdata_in[0] = bus.C1_WDATA;
   assign wdata_in[1] = bus.C2_WDATA;

   // The word/byte offset bits of the request address carry no meaning:
   // a burst always starts at the line base.
   logic [2*LINE_LSB-1:0] unused_addr_lo;
   assign unused_addr_lo = {addr_in[1][LINE_LSB-1:0], addr_in[0][LINE_LSB-1:0]};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]         state_reg, state_next;
   logic [BEAT_W-1:0]  beat_reg,  beat_next;
   logic               owner_reg, owner_next;  // 0 = port 1, 1 = port 2
   logic               we_reg,    we_next;
   logic [31:LINE_LSB] line_reg,  line_next;

`ifdef ARB_ROUND_ROBIN_EN
   // Port granted most recently; reset value means "port 1 was last",
   // so the very first tie goes to port 2.
   logic               last_reg,  last_next;
`endif

   // ------------------------------------------------------------------
   // Owner selection for the IDLE state
   // ------------------------------------------------------------------
   logic pick;

   always_comb begin
      pick = 1'b0;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = ~last_reg;
`else
            pick = 1'b1;
`endif
         end
         default: pick = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      owner_next = owner_reg;
      we_next    = we_reg;
      line_next  = line_reg;
`ifdef ARB_ROUND_ROBIN_EN
      last_next  = last_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (|req) begin
               // WE and ADDR are captured here and never looked at again,
               // so requesters may change them freely once granted.
               owner_next = pick;
               we_next    = we_in[pick];
               line_next  = addr_in[pick][31:LINE_LSB];
               beat_next  = '0;
               state_next = ST_BURST;
`ifdef ARB_ROUND_ROBIN_EN
               last_next  = pick;
`endif
            end
         end
         ST_BURST: begin
            // REQ is not consulted: a started burst always runs all beats.
            if (bus.M_ACK) begin
               beat_next = beat_reg + BEAT_W'(1);
               if (beat_reg == LAST_BEAT) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
      if (MEM_RST) begin
         state_reg <= ST_IDLE;
         beat_reg  <= '0;
         owner_reg <= 1'b0;
         we_reg    <= 1'b0;
         line_reg  <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         owner_reg <= owner_next;
         we_reg    <= we_next;
         line_reg  <= line_next;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
      if (MEM_RST) begin
         last_reg <= 1'b0;
      end else begin
         last_reg <= last_next;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   logic in_burst;
   logic in_done;

   assign in_burst = (state_reg == ST_BURST);
   assign in_done  = (state_reg == ST_DONE);

   logic [1:0] gnt;
   logic [1:0] rvalid;
   logic [1:0] wnext;
   logic [1:0] done;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic own;
         assign own        = (owner_reg == 1'(gi));
         // ownership is held through DONE so the requester sees GNT with DONE
         assign gnt[gi]    = own & (in_burst | in_done);
         assign rvalid[gi] = own & in_burst & bus.M_ACK & ~we_reg;
         assign wnext[gi]  = own & in_burst & bus.M_ACK &  we_reg;
         assign done[gi]   = own & in_done;
      end
   endgenerate

   logic [31:0] rdata;
   assign rdata = in_burst ? bus.M_RDATA : 32'h0;

   assign bus.C1_GNT    = gnt[0];
   assign bus.C1_RVALID = rvalid[0];
   assign bus.C1_WNEXT  = wnext[0];
   assign bus.C1_DONE   = done[0];
   assign bus.C1_RDATA  = rdata;

   assign bus.C2_GNT    = gnt[1];
   assign bus.C2_RVALID = rvalid[1];
   assign bus.C2_WNEXT  = wnext[1];
   assign bus.C2_DONE   = done[1];
   assign bus.C2_RDATA  = rdata;

   assign bus.M_EN    = in_burst;
   assign bus.M_WE    = in_burst & we_reg;
   assign bus.M_ADDR  = in_burst ? {line_reg, beat_reg, 2'b00} : 32'h0;
   assign bus.M_WDATA = in_burst ? wdata_in[owner_reg] : 32'h0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_line_arbiter
//
// Self-checking bench for mem_line_arbiter (WORDS = 8). A table of per-cycle
// vectors covers reset, M_ACK pulses while idle and a zero-wait port-1 fill;
// hand-written sequences cover a wait-stated writeback, tie arbitration,
// REQ dropped mid-burst and reset mid-burst. Every accepted memory beat is
// checked against a scoreboard queue filled when the request is issued.
// ---------------------------------------------------------------------------
module tb_mem_line_arbiter;

   localparam logic [31:0] WB1   = 32'h1000_0000;
   localparam logic [31:0] WB2   = 32'h2000_0000;
   localparam logic [31:0] RDMIX = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_line_arbiter_if bus ();

   mem_line_arbiter #(.WORDS(8)) dut (
      .MEM_CLK (clk),
      .MEM_RST (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // memory model: read data is a fixed function of the word address
   assign bus.M_RDATA = bus.M_ADDR ^ RDMIX;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   beat_t sb [$];
   beat_t mon_b;

   int c1_wcount = 0;
   int c2_wcount = 0;
   int ack_mode  = 0;   // 0 = manual, 1 = always high

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_burst(input bit port, input bit we, input logic [31:0] line,
                             input logic [31:0] wbase);
      for (int i = 0; i < 8; i++) begin
         beat_t b;
         b.port = port;
         b.we   = we;
         b.addr = {line[31:5], 5'b0} + 32'(i * 4);
         b.data = we ? (wbase + 32'(i)) : (b.addr ^ RDMIX);
         sb.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ack_mode == 1) bus.M_ACK = 1'b1;
      bus.C1_WDATA = WB1 + 32'(c1_wcount);
      bus.C2_WDATA = WB2 + 32'(c2_wcount);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_strobes"}, {bus.C1_GNT, bus.C2_GNT, bus.C1_RVALID, bus.C2_RVALID,
                                bus.C1_WNEXT, bus.C2_WNEXT, bus.C1_DONE, bus.C2_DONE,
                                bus.M_EN, bus.M_WE}, 32'h0);
      check({tag, "_maddr"},  bus.M_ADDR,   32'h0);
      check({tag, "_mwdata"}, bus.M_WDATA,  32'h0);
      check({tag, "_rdata1"}, bus.C1_RDATA, 32'h0);
      check({tag, "_rdata2"}, bus.C2_RDATA, 32'h0);
   endtask

   // Scoreboard monitor and requester write-pointer model
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.M_EN && bus.M_ACK) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 32'd1, 32'd0);
            end else begin
               mon_b = sb.pop_front();
               $display("beat port%0d we=%0d addr=%08h", mon_b.port + 1, mon_b.we, bus.M_ADDR);
               check("beat_addr", bus.M_ADDR, mon_b.addr);
               check("beat_we", 32'(bus.M_WE), 32'(mon_b.we));
               check("beat_gnt", {bus.C2_GNT, bus.C1_GNT}, mon_b.port ? 32'd2 : 32'd1);
               check("beat_strobes", {bus.C2_WNEXT, bus.C2_RVALID, bus.C1_WNEXT, bus.C1_RVALID},
                     32'd1 << (mon_b.port * 2 + mon_b.we));
               if (mon_b.we)
                  check("beat_wdata", bus.M_WDATA, mon_b.data);
               else
                  check("beat_rdata", mon_b.port ? bus.C2_RDATA : bus.C1_RDATA, mon_b.data);
            end
         end else begin
            check("quiet_strobes", {bus.C2_WNEXT, bus.C2_RVALID, bus.C1_WNEXT, bus.C1_RVALID}, 32'h0);
         end
         if (bus.C1_WNEXT) c1_wcount++;
         if (bus.C2_WNEXT) c2_wcount++;
         if (bus.C1_DONE)  c1_wcount = 0;
         if (bus.C2_DONE)  c2_wcount = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        req;
      logic        ack;
      logic        gnt;
      logic        en;
      logic [31:0] addr;
      logic        rvalid;
      logic        done;
   } vec_t;

   vec_t tbl [16];
   bit   exp_own [3];

   initial begin
      int dones;
      int nb;
      int beats;
      int idle_run;
      logic en_prev;
      bit seen;
      bit first;

      // ---- vector table: 4 idle cycles with M_ACK pulses, then C1 fill ----
      for (int r = 0; r < 16; r++) begin
         tbl[r].req = (r >= 4 && r <= 13);
         tbl[r].ack = (r != 1);
         tbl[r].gnt = (r >= 5 && r <= 13);
         tbl[r].en  = (r >= 5 && r <= 12);
         tbl[r].addr = (r >= 5 && r <= 12) ? 32'h12E0 + 32'((r - 5) * 4) : 32'h0;
         tbl[r].rvalid = (r >= 5 && r <= 12);
         tbl[r].done = (r == 13);
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = '{1'b1, 1'b0, 1'b1};
`else
      exp_own = '{1'b1, 1'b1, 1'b1};
`endif

      bus.C1_REQ = 0; bus.C1_WE = 0; bus.C1_ADDR = 32'h12E4; bus.C1_WDATA = WB1;
      bus.C2_REQ = 0; bus.C2_WE = 0; bus.C2_ADDR = 32'h0;    bus.C2_WDATA = WB2;
      bus.M_ACK  = 1;

      // ---- reset state ----
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      tick();
      rst = 0;

      // ---- table-driven: idle M_ACK pulses, then zero-wait C1 fill ----
      push_burst(1'b0, 1'b0, 32'h12E4, 32'h0);
      for (int r = 0; r < 16; r++) begin
         tick();
         bus.C1_REQ = tbl[r].req;
         bus.M_ACK  = tbl[r].ack;
         @(negedge clk);
         $display("vec %0d en=%0d addr=%08h rv=%0d done=%0d", r, bus.M_EN, bus.M_ADDR,
                  bus.C1_RVALID, bus.C1_DONE);
         check($sformatf("tbl%0d_gnt", r),    32'(bus.C1_GNT),    32'(tbl[r].gnt));
         check($sformatf("tbl%0d_en", r),     32'(bus.M_EN),      32'(tbl[r].en));
         check($sformatf("tbl%0d_addr", r),   bus.M_ADDR,         tbl[r].addr);
         check($sformatf("tbl%0d_rvalid", r), 32'(bus.C1_RVALID), 32'(tbl[r].rvalid));
         check($sformatf("tbl%0d_done", r),   32'(bus.C1_DONE),   32'(tbl[r].done));
         check($sformatf("tbl%0d_c2", r), {bus.C2_GNT, bus.C2_RVALID, bus.C2_WNEXT, bus.C2_DONE}, 32'h0);
      end

      // ---- tie: both ports request for three bursts ----
      ack_mode = 1;
      for (int i = 0; i < 3; i++)
         push_burst(exp_own[i], 1'b0, exp_own[i] ? 32'h0200 : 32'h0100, 32'h0);
      tick();
      bus.C1_REQ = 1; bus.C1_WE = 0; bus.C1_ADDR = 32'h0100;
      bus.C2_REQ = 1; bus.C2_WE = 0; bus.C2_ADDR = 32'h0200;
      @(negedge clk);
      dones = 0; nb = 0; idle_run = 0; en_prev = bus.M_EN; seen = 0;
      for (int c = 0; c < 120 && dones < 3; c++) begin
         tick();
         @(negedge clk);
         if (bus.M_EN && !en_prev) begin
            if (seen) check("tie_gap_ge2", 32'(idle_run >= 2), 32'd1);
            seen = 1;
            if (nb < 3) begin
               $display("tie burst %0d owner gnt=%0d%0d", nb, bus.C2_GNT, bus.C1_GNT);
               check($sformatf("tie_owner%0d", nb), {bus.C2_GNT, bus.C1_GNT}, exp_own[nb] ? 32'd2 : 32'd1);
            end
            nb++;
         end
         if (bus.M_EN) idle_run = 0; else idle_run++;
         if (bus.C1_DONE || bus.C2_DONE) dones++;
         en_prev = bus.M_EN;
      end
      check("tie_bursts", nb, 3);
      check("tie_dones", dones, 3);
      tick();
      bus.C1_REQ = 0; bus.C2_REQ = 0;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("tie_no_regrant", {bus.M_EN, bus.C1_GNT, bus.C2_GNT}, 32'h0);
      check("tie_sb_empty", sb.size(), 0);

      // ---- C2 writeback, M_ACK every second cycle ----
      ack_mode = 0;
      push_burst(1'b1, 1'b1, 32'h4A40, WB2);
      tick();
      bus.C2_REQ = 1; bus.C2_WE = 1; bus.C2_ADDR = 32'h4A40; bus.M_ACK = 0;
      @(negedge clk);
      for (int k = 1; k <= 18; k++) begin
         tick();
         bus.M_ACK = (k % 2 == 0) && (k <= 16);
         if (k == 3) begin
            bus.C2_ADDR = 32'hFFFF_FFC0;   // ignored after grant
            bus.C2_WE   = 0;
         end
         if (k == 18) bus.C2_REQ = 0;
         @(negedge clk);
         $display("wb cyc %0d en=%0d ack=%0d wnext=%0d wdata=%08h done=%0d", k, bus.M_EN,
                  bus.M_ACK, bus.C2_WNEXT, bus.M_WDATA, bus.C2_DONE);
         if (k <= 16) begin
            check("wb_en", 32'(bus.M_EN), 32'd1);
            check("wb_we", 32'(bus.M_WE), 32'd1);
            check("wb_wnext", 32'(bus.C2_WNEXT), 32'(k % 2 == 0));
            check("wb_wdata", bus.M_WDATA, bus.C2_WDATA);
         end
         check($sformatf("wb_done_c%0d", k), 32'(bus.C2_DONE), 32'(k == 17));
         if (k == 17) check("wb_done_gnt", {bus.M_EN, bus.C2_GNT}, 32'd1);
      end
      check("wb_sb_empty", sb.size(), 0);
      bus.C2_ADDR = 32'h0;

      // ---- REQ dropped after beat 2 ----
      ack_mode = 1;
      push_burst(1'b0, 1'b0, 32'h3300, 32'h0);
      tick();
      bus.C1_REQ = 1; bus.C1_WE = 0; bus.C1_ADDR = 32'h3300;
      @(negedge clk);
      beats = 0; dones = 0;
      for (int k = 1; k < 40 && dones == 0; k++) begin
         tick();
         if (k == 4) bus.C1_REQ = 0;
         @(negedge clk);
         if (bus.M_EN && bus.M_ACK) beats++;
         if (bus.C1_DONE) dones++;
      end
      check("drop_beats", beats, 8);
      check("drop_done", dones, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         check("drop_no_regrant", {bus.M_EN, bus.C1_GNT, bus.C2_GNT}, 32'h0);
      end

      // ---- reset asserted at beat 4 ----
      push_burst(1'b0, 1'b0, 32'h5520, 32'h0);
      tick();
      bus.C1_REQ = 1; bus.C1_ADDR = 32'h5520;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         tick();
         @(negedge clk);
      end
      tick();
      check("rst_pre_addr", bus.M_ADDR, 32'h5530);
      #1 rst = 1;
      #1 check_all_zero("rst_async");
      check("rst_sb_left", sb.size(), 4);
      sb.delete();
      @(negedge clk);
      check_all_zero("rst_hold");
      push_burst(1'b0, 1'b0, 32'h5520, 32'h0);
      tick();
      rst = 0;
      beats = 0; dones = 0; first = 1;
      for (int k = 0; k < 40 && dones == 0; k++) begin
         tick();
         @(negedge clk);
         if (bus.M_EN && first) begin
            check("rst_restart_addr", bus.M_ADDR, 32'h5520);
            first = 0;
         end
         if (bus.M_EN && bus.M_ACK) beats++;
         if (bus.C1_DONE) dones++;
      end
      check("rst_restart_beats", beats, 8);
      check("rst_restart_done", dones, 1);
      tick();
      bus.C1_REQ = 0;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("final_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
